// File: rtl/pagerank_pkg.sv
// Shared types and constants for the PageRank scatter engine.
package pagerank_pkg;

   localparam int DOUBLE_W  = 64;
   localparam int NODE_ID_W = 32;

   localparam logic [DOUBLE_W-1:0] DBL_ZERO = 64'h0000000000000000;
   localparam logic [DOUBLE_W-1:0] DBL_ONE  = 64'h3FF0000000000000;
   localparam logic [DOUBLE_W-1:0] DBL_HALF = 64'h3FE0000000000000;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LATCH,
      S_MUL,
      S_WAIT_MUL,
      S_SEND,
      S_WAIT_ACK,
      S_DONE
   } scatter_state_e;

endpackage

// File: rtl/pagerank_scatter_issue_if.sv
// Scatter-to-gather handshake: one (contribution, dst) pair per ack.
interface pagerank_scatter_issue_if;
   import pagerank_pkg::*;

   logic [DOUBLE_W-1:0]  page_rank_scatter;
   logic [NODE_ID_W-1:0] dest_id;
   logic                 pagerank_ready;
   logic                 update_complete;

   modport master (
      output page_rank_scatter, dest_id, pagerank_ready,
      input  update_complete
   );

   modport slave (
      input  page_rank_scatter, dest_id, pagerank_ready,
      output update_complete
   );

endinterface

// File: rtl/pagerank_scatter_issue_dawson_multiplier.sv
// Pipelined IEEE double multiply, round-to-nearest-even, subnormals flushed to zero.
module dawson_multiplier
   import pagerank_pkg::*;
#(
   parameter int LATENCY = 3
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                ready_in,
   input  logic [DOUBLE_W-1:0] a,
   input  logic [DOUBLE_W-1:0] b,
   output logic [DOUBLE_W-1:0] out,
   output logic                ready_out
);

   logic [10:0]  ea, eb;
   logic         sgn;
   logic         a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
   logic [105:0] prod;
   logic [52:0]  mant;
   logic         rnd, sticky, shift, carry;
   logic [53:0]  mant_r;
   logic [51:0]  frac;
   logic [12:0]  e_adj;
   logic [DOUBLE_W-1:0] res;

   logic [LATENCY-1:0]               vld_pipe;
   logic [LATENCY-1:0][DOUBLE_W-1:0] res_pipe;

   always_comb begin
      ea     = a[62:52];
      eb     = b[62:52];
      sgn    = a[63] ^ b[63];
      a_zero = (ea == 11'd0);
      b_zero = (eb == 11'd0);
      a_inf  = (ea == 11'h7FF) && (a[51:0] == 52'd0);
      b_inf  = (eb == 11'h7FF) && (b[51:0] == 52'd0);
      a_nan  = (ea == 11'h7FF) && (a[51:0] != 52'd0);
      b_nan  = (eb == 11'h7FF) && (b[51:0] != 52'd0);
      prod   = 106'({1'b1, a[51:0]}) * 106'({1'b1, b[51:0]});
      // product of two [1,2) mantissas lands in [1,4): renormalise on bit 105
      if (prod[105]) begin
         mant   = prod[105:53];
         rnd    = prod[52];
         sticky = |prod[51:0];
         shift  = 1'b1;
      end else begin
         mant   = prod[104:52];
         rnd    = prod[51];
         sticky = |prod[50:0];
         shift  = 1'b0;
      end
      mant_r = {1'b0, mant} + 54'(rnd & (sticky | mant[0]));
      carry  = mant_r[53];
      frac   = carry ? mant_r[52:1] : mant_r[51:0];
      e_adj  = {2'b00, ea} + {2'b00, eb} + 13'(shift) + 13'(carry);
      res    = {sgn, 11'(e_adj - 13'd1023), frac};
      if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
         res = 64'h7FF8000000000000;
      else if (a_inf || b_inf)
         res = {sgn, 11'h7FF, 52'd0};
      else if (a_zero || b_zero || e_adj <= 13'd1023)
         res = {sgn, 63'd0};
      else if (e_adj >= 13'd3070)
         res = {sgn, 11'h7FF, 52'd0};
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         vld_pipe <= '0;
         res_pipe <= '0;
      end else begin
         vld_pipe[0] <= ready_in;
         res_pipe[0] <= res;
         for (int i = 1; i < LATENCY; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
            res_pipe[i] <= res_pipe[i-1];
         end
      end
   end

   assign ready_out = vld_pipe[LATENCY-1];
   assign out       = res_pipe[LATENCY-1];

endmodule

// File: rtl/pagerank_scatter_issue.sv
// PageRank scatter phase: walk one partition's edges, issue rank[src]*inv_outdeg[src] to gather.
module pagerank_scatter_issue
   import pagerank_pkg::*;
#(
   parameter int NODES_IN_GRAPH = 32,
   parameter int EDGE_ADDR_W    = 32,
   parameter int MUL_LATENCY    = 3
) (
   input  logic                                    clock,
   input  logic                                    reset,
   input  logic                                    pagerank_enable,
   input  logic                                    start,
   input  logic [EDGE_ADDR_W-1:0]                  num_edges,
   output logic                                    edge_rd_en,
   output logic [EDGE_ADDR_W-1:0]                  edge_rd_addr,
   input  logic [NODE_ID_W-1:0]                    edge_src,
   input  logic [NODE_ID_W-1:0]                    edge_dst,
   input  logic [NODES_IN_GRAPH-1:0][DOUBLE_W-1:0] rank_in,
   input  logic [NODES_IN_GRAPH-1:0][DOUBLE_W-1:0] inv_outdeg,
   pagerank_scatter_issue_if.master                gather,
   output logic                                    scatter_operation_complete,
   output logic                                    busy,
   output logic                                    edge_error
);

   localparam int IDX_W = (NODES_IN_GRAPH > 1) ? $clog2(NODES_IN_GRAPH) : 1;

   scatter_state_e         state;
   logic [EDGE_ADDR_W-1:0] idx, remaining;
   logic [IDX_W-1:0]       src_q;
   logic [NODE_ID_W-1:0]   dst_q;

   logic                id_bad, step, last_edge;
   logic                mul_go, mul_rdy, mul_hit, mul_avail;
   logic [DOUBLE_W-1:0] mul_a, mul_b, mul_out, mul_res, mul_val;

   assign id_bad    = (edge_src >= NODE_ID_W'(NODES_IN_GRAPH)) ||
                      (edge_dst >= NODE_ID_W'(NODES_IN_GRAPH));
   assign step      = (state == S_LATCH && id_bad) ||
                      (state == S_WAIT_ACK && gather.update_complete);
   assign last_edge = (remaining == EDGE_ADDR_W'(1));

   // issue is gated by enable so a frozen MUL state never re-launches
   assign mul_go    = pagerank_enable && (state == S_MUL);
   assign mul_a     = rank_in[src_q];
   assign mul_b     = inv_outdeg[src_q];
   assign mul_avail = mul_rdy | mul_hit;
   assign mul_val   = mul_hit ? mul_res : mul_out;

   dawson_multiplier #(.LATENCY(MUL_LATENCY)) u_mul (
      .clock     (clock),
      .reset     (reset),
      .ready_in  (mul_go),
      .a         (mul_a),
      .b         (mul_b),
      .out       (mul_out),
      .ready_out (mul_rdy)
   );

   // the multiplier keeps running while disabled; park its result so it isn't lost
   always_ff @(posedge clock) begin
      if (reset) begin
         mul_hit <= 1'b0;
         mul_res <= '0;
      end else if (pagerank_enable && state == S_WAIT_MUL) begin
         mul_hit <= 1'b0;
      end else if (mul_rdy) begin
         mul_hit <= 1'b1;
         mul_res <= mul_out;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state                      <= S_IDLE;
         idx                        <= '0;
         remaining                  <= '0;
         src_q                      <= '0;
         dst_q                      <= '0;
         edge_rd_en                 <= 1'b0;
         edge_rd_addr               <= '0;
         gather.page_rank_scatter   <= '0;
         gather.dest_id             <= '0;
         gather.pagerank_ready      <= 1'b0;
         scatter_operation_complete <= 1'b0;
         busy                       <= 1'b0;
         edge_error                 <= 1'b0;
      end else if (pagerank_enable) begin
         edge_rd_en            <= 1'b0;
         gather.pagerank_ready <= 1'b0;
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  if (num_edges == '0) begin
                     state                      <= S_DONE;
                     scatter_operation_complete <= 1'b1;
                  end else begin
                     state                      <= S_FETCH;
                     idx                        <= '0;
                     remaining                  <= num_edges;
                     edge_error                 <= 1'b0;
                     scatter_operation_complete <= 1'b0;
                     busy                       <= 1'b1;
                     edge_rd_en                 <= 1'b1;
                     edge_rd_addr               <= '0;
                  end
               end
            end
            S_FETCH: state <= S_LATCH;
            S_LATCH: begin
               src_q <= edge_src[IDX_W-1:0];
               dst_q <= edge_dst;
               if (id_bad) edge_error <= 1'b1;
               else        state      <= S_MUL;
            end
            S_MUL: state <= S_WAIT_MUL;
            S_WAIT_MUL: begin
               if (mul_avail) begin
                  gather.page_rank_scatter <= mul_val;
                  gather.dest_id           <= dst_q;
                  gather.pagerank_ready    <= 1'b1;
                  state                    <= S_SEND;
               end
            end
            S_SEND:     state <= S_WAIT_ACK;
            S_WAIT_ACK: ;
            default:    state <= S_IDLE;
         endcase
         // retire the current edge (skipped or acknowledged)
         if (step) begin
            idx       <= idx + 1'b1;
            remaining <= remaining - 1'b1;
            if (last_edge) begin
               state                      <= S_DONE;
               scatter_operation_complete <= 1'b1;
               busy                       <= 1'b0;
            end else begin
               state        <= S_FETCH;
               edge_rd_en   <= 1'b1;
               edge_rd_addr <= idx + 1'b1;
            end
         end
      end
   end

endmodule
